// File: rtl/ttl_serial_tx.sv
// Serial frame transmitter: start bit, WIDTH data bits, stop bit, each DIV clocks long.
// Word is captured on the valid/ready handshake; every output is registered.
module ttl_serial_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DIV       = 4,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rd,
    input  logic [WIDTH-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sdo,
    output logic             bit_strobe,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             last_cyc;
    logic             tx_bit;
    logic             sdo_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        last_cyc = (cnt_q == CNT_MAX);

        case (state_q)
            StIdle: begin
                if (load_valid && load_ready) begin
                    state_d = StStart;
                    cnt_d   = '0;
                    idx_d   = '0;
                    shreg_d = d;
                end
            end
            StStart: begin
                cnt_d = last_cyc ? '0 : cnt_q + 1'b1;
                if (last_cyc) state_d = StData;
            end
            StData: begin
                cnt_d = last_cyc ? '0 : cnt_q + 1'b1;
                if (last_cyc) begin
                    if (idx_q == IDX_MAX) begin
                        state_d = StStop;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        // Outgoing bit always sits at the end facing the transmit order.
                        shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                    end
                end
            end
            StStop: begin
                cnt_d = last_cyc ? '0 : cnt_q + 1'b1;
                if (last_cyc) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        tx_bit = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
        case (state_d)
            StStart: sdo_d = 1'b0;
            StData:  sdo_d = tx_bit;
            default: sdo_d = 1'b1;
        endcase
    end

    // Outputs are decoded from next-state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rd) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            sdo        <= 1'b1;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            bit_strobe <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            sdo        <= sdo_d;
            load_ready <= (state_d == StIdle);
            busy       <= (state_d != StIdle);
            done       <= (state_d == StStop) && (cnt_d == CNT_MAX);
            bit_strobe <= (state_d != StIdle) && (cnt_d == '0);
        end
    end

endmodule

// File: tb/tb_ttl_serial_tx.sv
// Directed bench for ttl_serial_tx: three instances cover LSB/MSB order at DIV=4 and DIV=1.
module tb_ttl_serial_tx;

    logic clk = 1'b0;
    logic rd  = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] d_a = '0, d_b = '0, d_c = '0;
    logic lv_a = 0, lv_b = 0, lv_c = 0;
    logic rdy_a, sdo_a, stb_a, busy_a, done_a;
    logic rdy_b, sdo_b, stb_b, busy_b, done_b;
    logic rdy_c, sdo_c, stb_c, busy_c, done_c;

    ttl_serial_tx #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b0)) u_a (
        .clk(clk), .rd(rd), .d(d_a), .load_valid(lv_a), .load_ready(rdy_a),
        .sdo(sdo_a), .bit_strobe(stb_a), .busy(busy_a), .done(done_a));
    ttl_serial_tx #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b1)) u_b (
        .clk(clk), .rd(rd), .d(d_b), .load_valid(lv_b), .load_ready(rdy_b),
        .sdo(sdo_b), .bit_strobe(stb_b), .busy(busy_b), .done(done_b));
    ttl_serial_tx #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0)) u_c (
        .clk(clk), .rd(rd), .d(d_c), .load_valid(lv_c), .load_ready(rdy_c),
        .sdo(sdo_c), .bit_strobe(stb_c), .busy(busy_c), .done(done_c));

    int  checks = 0;
    int  errors = 0;
    time accept_t;
    logic o_rdy, o_sdo, o_stb, o_busy, o_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic get(input int s);
        case (s)
            0: begin o_rdy = rdy_a; o_sdo = sdo_a; o_stb = stb_a; o_busy = busy_a; o_done = done_a; end
            1: begin o_rdy = rdy_b; o_sdo = sdo_b; o_stb = stb_b; o_busy = busy_b; o_done = done_b; end
            default: begin
                o_rdy = rdy_c; o_sdo = sdo_c; o_stb = stb_c; o_busy = busy_c; o_done = done_c;
            end
        endcase
    endtask

    task automatic drive(input int s, input logic [7:0] w, input logic v);
        case (s)
            0: begin d_a = w; lv_a = v; end
            1: begin d_b = w; lv_b = v; end
            default: begin d_c = w; lv_c = v; end
        endcase
    endtask

    task automatic idle_chk(input int s, input string tag);
        get(s);
        chk({tag, ".sdo"}, o_sdo, 1'b1);
        chk({tag, ".rdy"}, o_rdy, 1'b1);
        chk({tag, ".busy"}, o_busy, 1'b0);
        chk({tag, ".done"}, o_done, 1'b0);
        chk({tag, ".stb"}, o_stb, 1'b0);
    endtask

    // Called at a negedge with the instance idle. exp[p] is sdo for bit period p.
    // keep holds load_valid and puts nxt on d from the first frame cycle on;
    // disturb offers a different word mid-frame. Returns at a negedge after the frame.
    task automatic run_frame(input int s, input logic [7:0] w, input logic [9:0] exp,
                             input int div, input bit keep, input logic [7:0] nxt,
                             input bit disturb, input string tag);
        int strobes = 0;
        int n = 10 * div;
        get(s);
        chk({tag, ".pre_rdy"}, o_rdy, 1'b1);
        drive(s, w, 1'b1);
        @(posedge clk);
        accept_t = $time;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            get(s);
            chk($sformatf("%s.sdo[%0d]", tag, c), o_sdo, exp[(c - 1) / div]);
            chk($sformatf("%s.stb[%0d]", tag, c), o_stb, ((c - 1) % div) == 0);
            chk($sformatf("%s.done[%0d]", tag, c), o_done, c == n);
            chk($sformatf("%s.busy[%0d]", tag, c), o_busy, 1'b1);
            chk($sformatf("%s.rdy[%0d]", tag, c), o_rdy, 1'b0);
            if (o_stb) strobes++;
            if (c == 1) drive(s, keep ? nxt : ~w, keep);
            if (disturb && c == 2) drive(s, 8'h5A, 1'b1);
            if (disturb && c == 6) drive(s, 8'h5A, 1'b0);
        end
        chk({tag, ".strobes"}, strobes, 10);
        @(negedge clk);
        get(s);
        chk({tag, ".post_rdy"}, o_rdy, 1'b1);
        chk({tag, ".post_busy"}, o_busy, 1'b0);
        chk({tag, ".post_sdo"}, o_sdo, 1'b1);
        chk({tag, ".post_done"}, o_done, 1'b0);
    endtask

    initial begin
        time t0;
        // Reset held 3 cycles with load_valid offered on every instance.
        drive(0, 8'hA5, 1'b1);
        drive(1, 8'hA5, 1'b1);
        drive(2, 8'hA5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) idle_chk(s, $sformatf("rst%0d_%0d", i, s));
        end
        drive(1, 8'h00, 1'b0);
        drive(2, 8'h00, 1'b0);
        rd = 1'b1;

        // 0xA5 LSB first; load_valid still high so the first released edge accepts.
        run_frame(0, 8'hA5, 10'b11_0100_1010, 4, 1'b0, 8'h00, 1'b0, "a_A5");
        // MSB first: 0xA5 is a bit palindrome, 0x01 shows the order.
        run_frame(1, 8'hA5, 10'b11_0100_1010, 4, 1'b0, 8'h00, 1'b0, "b_A5");
        run_frame(1, 8'h01, 10'b11_0000_0000, 4, 1'b0, 8'h00, 1'b0, "b_01");

        // DIV=1 back-to-back with load_valid held and d changed mid-frame.
        run_frame(2, 8'h3C, 10'b10_0111_1000, 1, 1'b1, 8'hC3, 1'b0, "c_3C");
        t0 = accept_t;
        run_frame(2, 8'hC3, 10'b11_1000_0110, 1, 1'b0, 8'h00, 1'b0, "c_C3");
        chk("c_gap", int'((accept_t - t0) / 10), 11);

        // Busy rejection: a different word offered mid-frame must not disturb or queue.
        run_frame(0, 8'hA5, 10'b11_0100_1010, 4, 1'b0, 8'h00, 1'b1, "a_rej");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            idle_chk(0, $sformatf("a_rej_idle%0d", i));
        end

        // Reset during data bit 3 of 0xFF (cycles E+17..E+20).
        drive(0, 8'hFF, 1'b1);
        @(posedge clk);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 1) drive(0, 8'hFF, 1'b0);
        end
        get(0);
        chk("mid.sdo_before", o_sdo, 1'b1);
        chk("mid.busy_before", o_busy, 1'b1);
        rd = 1'b0;
        @(negedge clk);
        rd = 1'b1;
        idle_chk(0, "mid_rst");
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            idle_chk(0, $sformatf("mid_after%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
